// File: rtl/draw_pkg.sv
// draw_pkg: shared types and widths for the sprite draw scheduler.
// Coordinate widths match a 320x240 VGA adapter with 3-bit colour.
package draw_pkg;

   localparam int X_W   = 9;
   localparam int Y_W   = 8;
   localparam int COL_W = 3;

   // Scheduler sequence for one slot: arm the drawer, stream its pixels,
   // flush the last registered pixel, then put the drawer back in reset.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARM     = 3'd1,
      DRAW    = 3'd2,
      FLUSH   = 3'd3,
      RELEASE = 3'd4
   } state_t;

endpackage

// File: rtl/draw_scheduler_if.sv
// draw_scheduler_if: drawer-side and VGA-side signals of the draw scheduler.
// slave = the scheduler, master = the surrounding drawers/adapter/requesters.
interface draw_scheduler_if #(
   parameter int NUM_SLOTS = 4,
   parameter int SLOT_W    = 2
);
   import draw_pkg::*;

   logic [NUM_SLOTS-1:0]       req;
   logic [NUM_SLOTS-1:0]       drw_done;
   logic [X_W*NUM_SLOTS-1:0]   drw_x;
   logic [Y_W*NUM_SLOTS-1:0]   drw_y;
   logic [COL_W*NUM_SLOTS-1:0] drw_colour;
   logic [NUM_SLOTS-1:0]       drw_enable;
   logic [NUM_SLOTS-1:0]       drw_reset_n;
   logic [X_W-1:0]             vga_x;
   logic [Y_W-1:0]             vga_y;
   logic [COL_W-1:0]           vga_colour;
   logic                       vga_plot;
   logic                       busy;
   logic                       slot_done;
   logic [SLOT_W-1:0]          slot_id;

   modport slave (
      input  req, drw_done, drw_x, drw_y, drw_colour,
      output drw_enable, drw_reset_n, vga_x, vga_y, vga_colour, vga_plot,
             busy, slot_done, slot_id
   );

   modport master (
      output req, drw_done, drw_x, drw_y, drw_colour,
      input  drw_enable, drw_reset_n, vga_x, vga_y, vga_colour, vga_plot,
             busy, slot_done, slot_id
   );

endinterface

// File: rtl/draw_scheduler_slot_picker.sv
// slot_picker: chooses the next slot to draw from the pending set.
// Default build: fixed priority, lowest index wins.
// With DRAW_SCHED_RR_EN defined: round-robin, the search starts at the slot
// after the last served one and wraps around.
module slot_picker #(
   parameter int NUM_SLOTS = 4,
   parameter int SLOT_W    = 2
) (
   input  logic [NUM_SLOTS-1:0] pend,
`ifdef DRAW_SCHED_RR_EN
   input  logic [SLOT_W-1:0]    last,
`endif
   output logic [SLOT_W-1:0]    idx,
   output logic                 valid
);

   // Scan candidates from lowest to highest priority so the best one is
   // the last assignment to stick.
   always_comb begin
      // NOTE: every output gets a default before the loop, otherwise a
      // cycle with nothing pending would hold the old value and infer a latch.
      idx   = '0;
      valid = 1'b0;
`ifdef DRAW_SCHED_RR_EN
      for (int k = NUM_SLOTS; k >= 1; k--) begin
         if (pend[(int'(last) + k) % NUM_SLOTS]) begin
            idx   = SLOT_W'((int'(last) + k) % NUM_SLOTS);
            valid = 1'b1;
         end
      end
`else
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (pend[i]) begin
            idx   = SLOT_W'(i);
            valid = 1'b1;
         end
      end
`endif
   end

endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: time-shares one VGA write port among NUM_SLOTS sprite
// drawers. One slot is served at a time: its drawer is taken out of reset,
// enabled until it flags its last pixel, and its coordinates are registered
// one cycle so they line up with the drawer's registered ROM colour.
// Optional macro: DRAW_SCHED_RR_EN (round-robin slot selection).
module draw_scheduler
   import draw_pkg::*;
#(
   parameter int NUM_SLOTS = 4,
   parameter int SLOT_W    = 2
) (
   input logic             clock_all,
   input logic             reset_all,
   draw_scheduler_if.slave bus
);

   state_t               st;
   logic [NUM_SLOTS-1:0] pending;
   logic [NUM_SLOTS-1:0] pending_nxt;
   logic [NUM_SLOTS-1:0] pick_in;
   logic [SLOT_W-1:0]    pick_idx;
   logic                 pick_valid;
   logic [SLOT_W-1:0]    slot_q;
   logic                 rereq;
   logic [X_W-1:0]       sel_x;
   logic [Y_W-1:0]       sel_y;
   logic [COL_W-1:0]     sel_colour;
   logic                 sel_done;
   logic [X_W-1:0]       x_q;
   logic [Y_W-1:0]       y_q;
   logic                 plot_q;
   logic [NUM_SLOTS-1:0] en;
   logic [NUM_SLOTS-1:0] drw_rst_n;

   // A request arriving in an idle cycle is served straight away, which is
   // what gives the three-cycle request-to-first-plot latency.
   assign pick_in = pending | bus.req;

   slot_picker #(
      .NUM_SLOTS (NUM_SLOTS),
      .SLOT_W    (SLOT_W)
   ) u_picker (
      .pend  (pick_in),
`ifdef DRAW_SCHED_RR_EN
      .last  (slot_q),
`endif
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // Signals of the drawer currently owned by the scheduler.
   assign sel_x      = bus.drw_x[int'(slot_q)*X_W +: X_W];
   assign sel_y      = bus.drw_y[int'(slot_q)*Y_W +: Y_W];
   assign sel_colour = bus.drw_colour[int'(slot_q)*COL_W +: COL_W];
   assign sel_done   = bus.drw_done[slot_q];

   // Sequence one slot through arm, draw, flush and release.
   always_ff @(posedge clock_all) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of block ordering.
      if (!reset_all) begin
         st     <= IDLE;
         slot_q <= '0;
      end else begin
         case (st)
            IDLE: begin
               if (pick_valid) begin
                  slot_q <= pick_idx;
                  st     <= ARM;
               end
            end
            ARM:     st <= DRAW;
            DRAW:    if (sel_done) st <= FLUSH;
            FLUSH:   st <= RELEASE;
            RELEASE: st <= IDLE;
            default: st <= IDLE;
         endcase
      end
   end

   // Register the drawer coordinate; the plot strobe trails each DRAW cycle.
   always_ff @(posedge clock_all) begin
      if (!reset_all) begin
         x_q    <= '0;
         y_q    <= '0;
         plot_q <= 1'b0;
      end else begin
         plot_q <= (st == DRAW);
         if (st == DRAW) begin
            x_q <= sel_x;
            y_q <= sel_y;
         end
      end
   end

   // Release clears the served bit unless that slot asked again after its
   // service started (or asks in this very cycle): the new request wins.
   always_comb begin
      pending_nxt = pending | bus.req;
      if (st == RELEASE && !rereq && !bus.req[slot_q]) begin
         pending_nxt[slot_q] = 1'b0;
      end
   end

   // Pending set and the "asked again while being served" flag.
   always_ff @(posedge clock_all) begin
      if (!reset_all) begin
         pending <= '0;
         rereq   <= 1'b0;
      end else begin
         pending <= pending_nxt;
         if (st == IDLE) begin
            rereq <= 1'b0;
         end else if (bus.req[slot_q]) begin
            rereq <= 1'b1;
         end
      end
   end

   // Drawer controls: only the served drawer leaves reset, and only in
   // ARM/DRAW/FLUSH; it is enabled only while its pixels are being taken.
   always_comb begin
      en        = '0;
      drw_rst_n = '0;
      case (st)
         ARM, FLUSH: drw_rst_n[slot_q] = 1'b1;
         DRAW: begin
            drw_rst_n[slot_q] = 1'b1;
            en[slot_q]        = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.drw_enable  = en;
   assign bus.drw_reset_n = drw_rst_n;
   assign bus.vga_x       = x_q;
   assign bus.vga_y       = y_q;
   assign bus.vga_colour  = sel_colour;
   assign bus.vga_plot    = plot_q;
   assign bus.busy        = (st != IDLE);
   assign bus.slot_done   = (st == RELEASE);
   assign bus.slot_id     = slot_q;

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 Parameter: NUM_SLOTS, 4, number of sprite-drawer slots (2..8).
REQ-002 Parameter: SLOT_W, 2, width of slot index; SHALL equal ceil(log2(NUM_SLOTS)).
REQ-003 Port: clock_all  in  1  single clock, all logic on posedge.
REQ-004 Port: reset_all  in  1  synchronous, active-low reset.
REQ-005 Port: req  in  NUM_SLOTS  one-cycle redraw-request pulse per slot.
REQ-006 Port: drw_done  in  NUM_SLOTS  per-drawer last-pixel flag.
REQ-007 Port: drw_x  in  9*NUM_SLOTS  packed drawer x (slot i at [9i+8:9i]).
REQ-008 Port: drw_y  in  8*NUM_SLOTS  packed drawer y (slot i at [8i+7:8i]).
REQ-009 Port: drw_colour  in  3*NUM_SLOTS  packed drawer ROM colour, valid one cycle after its coordinate.
REQ-010 Port: drw_enable  out  NUM_SLOTS  per-drawer enable, one-hot or zero.
REQ-011 Port: drw_reset_n  out  NUM_SLOTS  per-drawer active-low sync reset.
REQ-012 Port: vga_x  out  9  pixel x to VGA adapter.
REQ-013 Port: vga_y  out  8  pixel y.
REQ-014 Port: vga_colour  out  3  pixel colour.
REQ-015 Port: vga_plot  out  1  write strobe.
REQ-016 Port: busy  out  1  high in any state other than IDLE.
REQ-017 Port: slot_done  out  1  one-cycle pulse when a slot finishes.
REQ-018 Port: slot_id  out  SLOT_W  index of slot being or last served.

Function
REQ-019 Pending register: bit i set on req[i]; cleared in RELEASE for the served slot; set and clear same cycle -> set wins (slot redrawn again).
REQ-020 States: IDLE, ARM, DRAW, FLUSH, RELEASE.
REQ-021 IDLE: any pending -> select slot (REQ-027), load slot_id, go ARM; none -> stay.
REQ-022 ARM (1 cycle): drw_reset_n[slot_id]=1, drw_enable=0; -> DRAW.
REQ-023 DRAW: drw_enable[slot_id]=1; each cycle register drw_x/drw_y of slot_id into vga_x/vga_y; vga_plot = 1 one cycle after each DRAW cycle; drw_done[slot_id]=1 -> FLUSH.
REQ-024 FLUSH (1 cycle): drw_enable=0; vga_plot=1 for the final registered coordinate; vga_colour = drw_colour[slot_id] directly (aligned with registered x/y).
REQ-025 RELEASE (1 cycle): drw_reset_n[slot_id]=0, vga_plot=0, slot_done=1, pending[slot_id] cleared; -> IDLE.
REQ-026 Unselected drawers: drw_enable=0, drw_reset_n=0 at all times; selected drawer's drw_reset_n=0 in IDLE and RELEASE.
REQ-027 Selection: lowest-index pending slot (fixed priority) unless REQ-034 applies.
REQ-028 Latency: req in IDLE -> first vga_plot 3 cycles later; sprite of P pixels -> P plots exactly, P+4 cycles IDLE-to-IDLE.
REQ-029 vga_plot never asserted in IDLE, ARM or RELEASE; at most one drw_enable bit high.
REQ-030 Out-of-range slot_id (NUM_SLOTS not power of 2) unreachable; req bits beyond NUM_SLOTS ignored.

Reset
REQ-031 reset_all=0 at a clock edge: state IDLE, pending=0, slot_id=0, vga_x=0, vga_y=0, vga_plot=0, slot_done=0, busy=0, drw_enable=0, drw_reset_n=0.
REQ-032 Reset mid-DRAW: abort with no further plot; the interrupted request is lost.
REQ-033 req during reset ignored.

Configuration
REQ-034 Macro DRAW_SCHED_RR_EN defined: round-robin, search starts at (last served slot+1) mod NUM_SLOTS; undefined: fixed priority per REQ-027; all other behaviour identical.

Structure
REQ-035 Shared package draw_pkg: state enum (IDLE..RELEASE), coordinate widths 9/8, colour width 3.
REQ-036 One sub-module: slot_picker (combinational pending + last-served -> slot index + valid), holding the RR/fixed choice.

Verification
REQ-037 Single: req[1] pulse, drawer 1 sprite 158x85 (done at x=157,y=84) -> 13430 plots, slot_done with slot_id=1, busy low after.
REQ-038 Contention: req=4'b1010 same cycle -> slot 1 then slot 3 (fixed); with DRAW_SCHED_RR_EN and last served 1 -> slot 3 first.
REQ-039 Re-request: req[2] during slot 2 DRAW -> slot 2 served twice, two slot_done pulses.
REQ-040 Alignment: drawer colour = f(x,y) pattern -> every plotted vga_colour matches f(vga_x,vga_y); first plot at (0,0), last at (157,84).
REQ-041 Reset mid-DRAW after 100 plots -> next cycle vga_plot=0, pending=0, all drw_reset_n=0.
REQ-042 Exclusion: random req stream 10k cycles -> drw_enable never multi-hot, no plot outside DRAW/FLUSH.
